// File: rtl/perceptron_cmd_engine_if.sv
// perceptron_cmd_engine_if: RX/TX byte-buffer handshake between the UARTs and the command engine
interface perceptron_cmd_engine_if;
   logic [7:0] rx_data;
   logic       rx_data_present;
   logic       rx_read;
   logic [7:0] tx_data;
   logic       tx_write;
   logic       tx_full;
   logic       busy;
   modport master (input rx_data, rx_data_present, tx_full, output rx_read, tx_data, tx_write, busy);
   modport slave (output rx_data, rx_data_present, tx_full, input rx_read, tx_data, tx_write, busy);
endinterface

// File: rtl/perceptron_cmd_engine.sv
// perceptron_cmd_engine: W/X frame parser, weight store and sequential MAC; PERCEPTRON_ACC_ECHO_EN adds a saturated acc echo byte
module perceptron_cmd_engine #(
   parameter int N_INPUTS  = 4,
   parameter int ACC_WIDTH = 20
) (
   input logic clk,
   input logic reset,
   perceptron_cmd_engine_if.master bus
);
   localparam int IW = $clog2(N_INPUTS + 1);
   localparam int AW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
   localparam logic [IW-1:0] LAST_W = IW'(N_INPUTS);
   localparam logic [IW-1:0] LAST_X = IW'(N_INPUTS - 1);
   localparam logic signed [ACC_WIDTH-1:0] ZERO = '0;
   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, MAC, RESP} state_t;
   state_t state, next;
   logic [IW-1:0] idx;
   logic [AW-1:0] ai;
   logic signed [7:0] w [N_INPUTS];
   logic signed [7:0] ws [N_INPUTS];
   logic signed [7:0] x [N_INPUTS];
   logic signed [7:0] bias;
   logic signed [7:0] wi, xi;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [15:0] prod;
   logic [7:0] resp, cls_byte, byte_out, tx_q;
   logic eval, rd, wr_q, pop, wr, last;
   assign ai = AW'(idx);
   assign wi = w[ai];
   assign xi = x[ai];
   assign prod = $signed({{8{wi[7]}}, wi}) * $signed({{8{xi[7]}}, xi});
   assign pop = bus.rx_data_present && !rd && (state == IDLE || state == LOAD_W || state == LOAD_X);
   assign wr = state == RESP && !wr_q && !bus.tx_full;
   assign cls_byte = eval ? (acc < ZERO ? 8'h30 : 8'h31) : resp;
`ifdef PERCEPTRON_ACC_ECHO_EN
   logic sat_hi, sat_lo;
   logic [7:0] sat;
   assign sat_hi = !acc[ACC_WIDTH-1] && |acc[ACC_WIDTH-2:7];
   assign sat_lo = acc[ACC_WIDTH-1] && !(&acc[ACC_WIDTH-2:7]);
   assign sat = sat_hi ? 8'h7f : sat_lo ? 8'h80 : acc[7:0];
   assign byte_out = (eval && idx != '0) ? sat : cls_byte;
   assign last = !eval || idx != '0;
`else
   assign byte_out = cls_byte;
   assign last = 1'b1;
`endif
   assign bus.rx_read = rd;
   assign bus.tx_write = wr_q;
   assign bus.tx_data = tx_q;
   assign bus.busy = state != IDLE;
   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : next;
   // next-state decode from opcode, byte counts and TX progress
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (pop) next = bus.rx_data == 8'h57 ? LOAD_W : bus.rx_data == 8'h58 ? LOAD_X : RESP;
         LOAD_W:  if (pop && idx == LAST_W) next = RESP;
         LOAD_X:  if (pop && idx == LAST_X) next = MAC;
         MAC:     if (idx == LAST_X) next = RESP;
         RESP:    if (wr && last) next = IDLE;
         default: next = IDLE;
      endcase
   end
   // datapath: strobes, byte capture, atomic weight commit, accumulate
   always_ff @(posedge clk) begin
      if (reset) begin
         rd   <= 1'b0;
         wr_q <= 1'b0;
         tx_q <= '0;
         idx  <= '0;
         eval <= 1'b0;
         resp <= '0;
         acc  <= '0;
         bias <= '0;
         w    <= '{default: '0};
         ws   <= '{default: '0};
         x    <= '{default: '0};
      end else begin
         rd   <= pop;
         wr_q <= wr;
         if (wr) tx_q <= byte_out;
         idx <= (next != state) ? '0 : (pop || wr || state == MAC) ? idx + 1'b1 : idx;
         if (state == IDLE && pop) begin
            eval <= bus.rx_data == 8'h58;
            resp <= bus.rx_data == 8'h57 ? 8'h06 : 8'h15;
         end
         if (state == LOAD_W && pop) begin
            if (idx == LAST_W) begin
               w    <= ws;
               bias <= bus.rx_data;
            end else ws[ai] <= bus.rx_data;
         end
         if (state == LOAD_X && pop) x[ai] <= bus.rx_data;
         if (state == LOAD_X && next == MAC) acc <= $signed({{(ACC_WIDTH-8){bias[7]}}, bias});
         if (state == MAC) acc <= acc + $signed({{(ACC_WIDTH-16){prod[15]}}, prod});
      end
   end
endmodule

// File: tb/tb_perceptron_cmd_engine.sv
// tb_perceptron_cmd_engine: directed frames with hand-computed responses, latency and handshake checks
module tb_perceptron_cmd_engine;
   localparam int N = 4;
`ifdef PERCEPTRON_ACC_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   int n_chk = 0, n_fail = 0, cyc = 0, last_rd = 0, first_tx = -1, rd_cnt = 0, rel = 0, c0 = 0;
   logic prev_rd = 1'b0, prev_full = 1'b0;
   always #5 clk = ~clk;
   perceptron_cmd_engine_if bus();
   perceptron_cmd_engine #(.N_INPUTS(N), .ACC_WIDTH(20)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_rx();
      bus.rx_data_present = rxq.size() != 0;
      bus.rx_data = rxq.size() != 0 ? rxq[0] : 8'h00;
   endtask

   task automatic cycle();
      prev_full = bus.tx_full;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rx_read === 1'b1) begin
         check("rd_gap", {31'b0, prev_rd}, 0);
         last_rd = cyc;
         rd_cnt++;
         if (rxq.size() > 0) void'(rxq.pop_front());
      end
      if (bus.tx_write === 1'b1) begin
         check("wr_full", {31'b0, prev_full}, 0);
         txq.push_back(bus.tx_data);
         if (first_tx < 0) first_tx = cyc;
      end
      prev_rd = bus.rx_read === 1'b1;
      drive_rx();
   endtask

   task automatic send(input logic [63:0] v, input int n);
      logic [63:0] s;
      for (int i = 0; i < n; i++) begin
         s = v >> (8 * (n - 1 - i));
         rxq.push_back(s[7:0]);
      end
      drive_rx();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run(input int max);
      int q = 0;
      int i = 0;
      while (q < 3 && i < max) begin
         cycle();
         i++;
         q = (rxq.size() == 0 && !bus.busy && !bus.tx_write) ? q + 1 : 0;
      end
      check("run_done", {31'b0, q >= 3}, 1);
   endtask

   task automatic clr();
      txq.delete();
      first_tx = -1;
   endtask

   task automatic expect_tx(input string tag, input logic [31:0] exp, input int n);
      logic [31:0] s;
      check({tag, "_cnt"}, txq.size(), n);
      for (int i = 0; i < n && i < txq.size(); i++) begin
         s = exp >> (8 * (n - 1 - i));
         check($sformatf("%s_b%0d", tag, i), {24'h0, txq[i]}, {24'h0, s[7:0]});
      end
      clr();
   endtask

   task automatic expect_x(input string tag, input logic [7:0] cls, input logic [7:0] sat);
      expect_tx(tag, ECHO ? {16'h0, cls, sat} : {24'h0, cls}, ECHO ? 2 : 1);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      rxq.delete();
      drive_rx();
      run_n(2);
      reset = 1'b0;
      clr();
   endtask

   task automatic load_w(input logic [39:0] v);
      send({8'h57, v}, N + 2);
      run(200);
      check("ack_lat", first_tx - last_rd, 1);
      expect_tx("ack", 32'h06, 1);
   endtask

   initial begin
      bus.rx_data = 8'h00;
      bus.rx_data_present = 1'b0;
      bus.tx_full = 1'b0;
      reset = 1'b1;
      run_n(2);
      check("rst_rd", {31'b0, bus.rx_read}, 0);
      check("rst_wr", {31'b0, bus.tx_write}, 0);
      check("rst_txd", {24'h0, bus.tx_data}, 0);
      check("rst_busy", {31'b0, bus.busy}, 0);
      reset = 1'b0;
      clr();
      load_w(40'h01020304F6);
      send(40'h5801010101, N + 1);
      run(200);
      check("x_lat", first_tx - last_rd, N + 1);
      expect_x("x_zero", 8'h31, 8'h00);
      send(40'h5801010100, N + 1);
      run(200);
      check("x_neg_lat", first_tx - last_rd, N + 1);
      expect_x("x_neg", 8'h30, 8'hFC);
      send(8'h41, 1);
      run(200);
      check("nak_lat", first_tx - last_rd, 1);
      expect_tx("nak", 32'h15, 1);
      check("nak_idle", {31'b0, bus.busy}, 0);
      send(40'h5801010100, N + 1);
      run(200);
      expect_x("x_after_nak", 8'h30, 8'hFC);
      pulse_reset();
      send(40'h5805050505, N + 1);
      run(200);
      expect_x("x_zero_w", 8'h31, 8'h00);
      load_w(40'h01020304F6);
      send(24'h577F7F, 3);
      run_n(12);
      check("part_busy", {31'b0, bus.busy}, 1);
      check("part_tx", txq.size(), 0);
      reset = 1'b1;
      cycle();
      check("abort_busy", {31'b0, bus.busy}, 0);
      check("abort_tx", txq.size(), 0);
      reset = 1'b0;
      clr();
      send(40'h5801010100, N + 1);
      run(200);
      expect_x("x_after_abort", 8'h31, 8'h00);
      load_w(40'h01020304F6);
      bus.tx_full = 1'b1;
      send(40'h5801010101, N + 1);
      run_n(24);
      send(8'h41, 1);
      c0 = rd_cnt;
      run_n(20);
      check("stall_rd", rd_cnt - c0, 0);
      check("stall_wr", txq.size(), 0);
      check("stall_busy", {31'b0, bus.busy}, 1);
      bus.tx_full = 1'b0;
      rel = cyc;
      run(200);
      check("rel_lat", first_tx - rel, 1);
      expect_tx("stall", ECHO ? 32'h00310015 : 32'h00003115, ECHO ? 3 : 2);
      load_w(40'h7F7F7F7F7F);
      send(40'h587F7F7F7F, N + 1);
      run(200);
      expect_x("sat_pos", 8'h31, 8'h7F);
      load_w(40'h8080808000);
      send(40'h587F7F7F7F, N + 1);
      run(200);
      expect_x("sat_neg", 8'h30, 8'h80);
      send(40'h5880808080, N + 1);
      run(200);
      expect_x("min_sq", 8'h31, 8'h7F);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
